// File: rtl/barrier_ctrl_multi.sv
// Multi-lane parking entry barriers sharing one occupancy counter, arbitrated lowest lane first.
// Optional macro BARR_HOLD_EN keeps a barrier open (HOLD) while VehPresent reports a vehicle.
module barrier_ctrl_multi #(
    parameter int N_LANES     = 2,
    parameter int OPEN_CYCLES = 6,
    parameter int CAPACITY    = 16
) (
    input  logic                            CLK,
    input  logic                            RSTn,
    input  logic [N_LANES-1:0]              MatrVal,
    input  logic [N_LANES-1:0]              VehPresent,
    input  logic                            SaidaVal,
    output logic [N_LANES-1:0]              Barreira,
    output logic [N_LANES-1:0]              Recusado,
    output logic [$clog2(CAPACITY+1)-1:0]   Ocupacao,
    output logic                            Cheio
);

    localparam int OCC_W = $clog2(CAPACITY + 1);

`ifdef BARR_HOLD_EN
    typedef enum logic [1:0] {CLOSED, OPEN, HOLD} state_t;
`else
    typedef enum logic [1:0] {CLOSED, OPEN} state_t;

    logic unused_veh;
    assign unused_veh = ^VehPresent;
`endif

    state_t             state [N_LANES];
    logic [7:0]         cnt   [N_LANES];
    logic [N_LANES-1:0] matr_prev;
    logic [N_LANES-1:0] matr_armed;
    logic               saida_prev;
    logic               saida_armed;
    logic [N_LANES-1:0] matr_rise;
    logic               saida_rise;
    logic [N_LANES-1:0] grant;
    logic [OCC_W-1:0]   ocup_next;
    int                 avail;
    int                 granted;
    int                 total;

    // The armed bits stay low until an input is seen at 0, so a level held through reset is not an edge.
    assign matr_rise  = MatrVal & ~matr_prev & matr_armed;
    assign saida_rise = SaidaVal & ~saida_prev & saida_armed;
    assign Cheio      = (Ocupacao == OCC_W'(CAPACITY));

    // Only the registered occupancy sets the free-space budget; a same-cycle exit frees nothing yet.
    always_comb begin
        avail   = CAPACITY - int'(Ocupacao);
        granted = 0;
        grant   = '0;
        for (int i = 0; i < N_LANES; i++) begin
            if (matr_rise[i] && (state[i] == CLOSED) && (granted < avail)) begin
                grant[i] = 1'b1;
                granted  = granted + 1;
            end
        end
        total = int'(Ocupacao) + granted;
        if (saida_rise && (total > 0))
            total = total - 1;
        ocup_next = OCC_W'(total);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            matr_prev   <= '0;
            matr_armed  <= '0;
            saida_prev  <= 1'b0;
            saida_armed <= 1'b0;
            Barreira    <= '0;
            Recusado    <= '0;
            Ocupacao    <= '0;
            for (int i = 0; i < N_LANES; i++) begin
                state[i] <= CLOSED;
                cnt[i]   <= 8'd0;
            end
        end else begin
            matr_prev   <= MatrVal;
            matr_armed  <= matr_armed | ~MatrVal;
            saida_prev  <= SaidaVal;
            saida_armed <= saida_armed | ~SaidaVal;
            Ocupacao    <= ocup_next;
            for (int i = 0; i < N_LANES; i++) begin
                Recusado[i] <= 1'b0;
                case (state[i])
                    CLOSED: begin
                        if (grant[i]) begin
                            state[i]    <= OPEN;
                            cnt[i]      <= 8'(OPEN_CYCLES);
                            Barreira[i] <= 1'b1;
                        end else if (matr_rise[i]) begin
                            Recusado[i] <= 1'b1;
                        end
                    end
                    OPEN: begin
                        if (matr_rise[i]) begin
                            cnt[i] <= 8'(OPEN_CYCLES);
                        end else if (cnt[i] <= 8'd1) begin
                            cnt[i] <= 8'd0;
`ifdef BARR_HOLD_EN
                            if (VehPresent[i]) begin
                                state[i] <= HOLD;
                            end else begin
                                state[i]    <= CLOSED;
                                Barreira[i] <= 1'b0;
                            end
`else
                            state[i]    <= CLOSED;
                            Barreira[i] <= 1'b0;
`endif
                        end else begin
                            cnt[i] <= cnt[i] - 8'd1;
                        end
                    end
`ifdef BARR_HOLD_EN
                    HOLD: begin
                        if (matr_rise[i]) begin
                            state[i] <= OPEN;
                            cnt[i]   <= 8'(OPEN_CYCLES);
                        end else if (!VehPresent[i]) begin
                            state[i]    <= CLOSED;
                            Barreira[i] <= 1'b0;
                        end
                    end
`endif
                    default: begin
                        state[i]    <= CLOSED;
                        Barreira[i] <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_barrier_ctrl_multi.sv
// Directed scoreboard bench for barrier_ctrl_multi: a default instance plus a CAPACITY=1 instance.
// Expectations are queued with the cycle they are due and compared on the falling clock edge.
module tb_barrier_ctrl_multi;

    logic       clk;
    logic       rst_n;
    logic [1:0] matr;
    logic [1:0] veh;
    logic       saida;
    logic [1:0] barreira;
    logic [1:0] recusado;
    logic [4:0] ocupacao;
    logic       cheio;

    logic [1:0] matr1;
    logic       saida1;
    logic [1:0] barreira1;
    logic [1:0] recusado1;
    logic [0:0] ocupacao1;
    logic       cheio1;

    typedef struct {
        int          cyc;
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_checks;
    int   n_fail;

    barrier_ctrl_multi dut (
        .CLK        (clk),
        .RSTn       (rst_n),
        .MatrVal    (matr),
        .VehPresent (veh),
        .SaidaVal   (saida),
        .Barreira   (barreira),
        .Recusado   (recusado),
        .Ocupacao   (ocupacao),
        .Cheio      (cheio)
    );

    barrier_ctrl_multi #(.N_LANES(2), .OPEN_CYCLES(6), .CAPACITY(1)) dut_c1 (
        .CLK        (clk),
        .RSTn       (rst_n),
        .MatrVal    (matr1),
        .VehPresent (2'b00),
        .SaidaVal   (saida1),
        .Barreira   (barreira1),
        .Recusado   (recusado1),
        .Ocupacao   (ocupacao1),
        .Cheio      (cheio1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] observe(int sel);
        case (sel)
            0:       return 32'(barreira);
            1:       return 32'(recusado);
            2:       return 32'(ocupacao);
            3:       return 32'(cheio);
            4:       return 32'(barreira1);
            5:       return 32'(recusado1);
            6:       return 32'(ocupacao1);
            7:       return 32'(cheio1);
            default: return 'x;
        endcase
    endfunction

    task automatic expect_at(int d, string tag, int sel, logic [31:0] v);
        sb.push_back('{cyc + d, tag, sel, v});
    endtask

    // Compare and retire every queued expectation due in the current cycle.
    task automatic check_output();
        logic [31:0] obs;
        int i;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc == cyc) begin
                obs = observe(sb[i].sel);
                n_checks++;
                assert (obs === sb[i].exp)
                else begin
                    n_fail++;
                    $error("[TB] FAIL %s cycle %0d: observed %0h expected %0h",
                           sb[i].tag, cyc, obs, sb[i].exp);
                end
                sb.delete(i);
            end else begin
                i++;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        check_output();
    endtask

    initial begin
        cyc      = 0;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        matr     = 2'b00;
        veh      = 2'b00;
        saida    = 1'b0;
        matr1    = 2'b00;
        saida1   = 1'b0;

        $display("[TB] reset state");
        tick();
        expect_at(1, "rst_barreira", 0, 0);
        expect_at(1, "rst_recusado", 1, 0);
        expect_at(1, "rst_ocupacao", 2, 0);
        expect_at(1, "rst_cheio",    3, 0);
        expect_at(1, "rst_ocup_c1",  6, 0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] single entry, barrier open six cycles");
        matr = 2'b01;
        for (int k = 1; k <= 6; k++) expect_at(k, "open6_barreira", 0, 2'b01);
        expect_at(7, "open6_closed", 0, 2'b00);
        expect_at(1, "open6_ocup",   2, 1);
        expect_at(7, "open6_ocup_after", 2, 1);
        tick();
        matr = 2'b00;
        repeat (6) tick();

        $display("[TB] lane 1 entry and reload while open");
        matr = 2'b10;
        expect_at(1, "lane1_ocup", 2, 2);
        tick();
        matr = 2'b00;
        tick();
        tick();
        matr = 2'b10;
        expect_at(1, "reload_ocup", 2, 2);
        expect_at(1, "reload_recusado", 1, 0);
        for (int k = 1; k <= 6; k++) expect_at(k, "reload_barreira", 0, 2'b10);
        expect_at(7, "reload_closed", 0, 2'b00);
        tick();
        matr = 2'b00;
        repeat (6) tick();

        $display("[TB] exits down to zero and saturation");
        saida = 1'b1;
        expect_at(1, "exit_ocup1", 2, 1);
        tick();
        saida = 1'b0;
        tick();
        saida = 1'b1;
        expect_at(1, "exit_ocup0", 2, 0);
        tick();
        saida = 1'b0;
        tick();
        saida = 1'b1;
        expect_at(1, "exit_saturate", 2, 0);
        tick();
        saida = 1'b0;
        tick();

        $display("[TB] simultaneous entry and exit nets out");
        matr  = 2'b01;
        saida = 1'b1;
        expect_at(1, "net_ocup",     2, 0);
        expect_at(1, "net_barreira", 0, 2'b01);
        tick();
        matr  = 2'b00;
        saida = 1'b0;
        repeat (7) tick();

        $display("[TB] capacity one, two lanes compete");
        matr1 = 2'b11;
        expect_at(1, "c1_barreira",  4, 2'b01);
        expect_at(1, "c1_recusado",  5, 2'b10);
        expect_at(2, "c1_rec_pulse", 5, 2'b00);
        expect_at(1, "c1_ocup",      6, 1);
        expect_at(1, "c1_cheio",     7, 1);
        tick();
        matr1 = 2'b00;
        tick();
        repeat (6) tick();

        $display("[TB] full, exit and entry in the same cycle");
        matr1  = 2'b01;
        saida1 = 1'b1;
        expect_at(1, "full_recusado", 5, 2'b01);
        expect_at(1, "full_barreira", 4, 2'b00);
        expect_at(1, "full_ocup",     6, 0);
        expect_at(1, "full_cheio",    7, 0);
        tick();
        matr1  = 2'b00;
        saida1 = 1'b0;
        tick();
        matr1 = 2'b01;
        expect_at(1, "later_barreira", 4, 2'b01);
        expect_at(1, "later_ocup",     6, 1);
        tick();
        matr1 = 2'b00;
        tick();

        $display("[TB] reset in the middle of an opening");
        matr = 2'b01;
        expect_at(1, "pre_rst_ocup", 2, 1);
        expect_at(3, "pre_rst_barreira", 0, 2'b01);
        tick();
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        expect_at(0, "midrst_barreira", 0, 2'b00);
        expect_at(0, "midrst_ocup",     2, 0);
        check_output();
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            expect_at(k, "held_barreira", 0, 2'b00);
            expect_at(k, "held_ocup",     2, 0);
        end
        repeat (3) tick();
        matr = 2'b00;
        tick();
        matr = 2'b01;
        expect_at(1, "rearm_barreira", 0, 2'b01);
        tick();
        matr = 2'b00;
        repeat (8) tick();

`ifdef BARR_HOLD_EN
        $display("[TB] hold while vehicle present");
        matr = 2'b01;
        veh  = 2'b01;
        for (int k = 1; k <= 10; k++) expect_at(k, "hold_barreira", 0, 2'b01);
        expect_at(11, "hold_released", 0, 2'b00);
        tick();
        matr = 2'b00;
        repeat (9) tick();
        veh = 2'b00;
        tick();
        repeat (2) tick();
`endif

        n_checks++;
        assert (sb.size() == 0)
        else begin
            n_fail++;
            $error("[TB] FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/barrier_ctrl_multi.md
BARRIER_CTRL_MULTI -- requirements
Module: barrier_ctrl_multi

Interface
REQ-001 The module SHALL have parameter N_LANES, default 2, number of entry lanes (1..8).
REQ-002 The module SHALL have parameter OPEN_CYCLES, default 6, barrier open time in clock cycles (2..255).
REQ-003 The module SHALL have parameter CAPACITY, default 16, number of parking spaces (1..255).
REQ-004 The module SHALL have ports, one per line:
- CLK  input  1  system clock, rising edge.
- RSTn  input  1  asynchronous, active-low reset.
- MatrVal  input  N_LANES  per-lane plate-valid level.
- VehPresent  input  N_LANES  per-lane vehicle-under-barrier sensor.
- SaidaVal  input  1  exit event level.
- Barreira  output  N_LANES  per-lane barrier open (1 = open).
- Recusado  output  N_LANES  one-cycle entry-refused pulse.
- Ocupacao  output  clog2(CAPACITY+1)  occupied spaces.
- Cheio  output  1  high when Ocupacao == CAPACITY.

Function
REQ-005 The module SHALL sample MatrVal, VehPresent and SaidaVal on the rising edge of CLK and act only on the rising edges of MatrVal[i] and SaidaVal, detected against a registered previous value.
REQ-006 Each lane SHALL run its own FSM with states CLOSED, OPEN and HOLD, plus an 8-bit down-counter.
REQ-007 In CLOSED, a MatrVal[i] rising edge that is granted SHALL move the lane to OPEN and load the counter with OPEN_CYCLES; Barreira[i] SHALL assert in the following cycle.
REQ-008 In OPEN, the counter SHALL decrement each cycle; when it reaches 0, the lane SHALL go to HOLD if VehPresent[i]=1, else to CLOSED; Barreira[i] SHALL be high for exactly OPEN_CYCLES cycles when no hold occurs.
REQ-009 In HOLD, Barreira[i] SHALL stay 1 until VehPresent[i] is sampled 0; the lane SHALL then enter CLOSED and deassert Barreira[i] in the next cycle.
REQ-010 A MatrVal[i] rising edge in OPEN or HOLD SHALL reload the counter with OPEN_CYCLES (HOLD returns to OPEN) and SHALL NOT change Ocupacao.
REQ-011 A granted entry SHALL increment Ocupacao by 1; a SaidaVal rising edge SHALL decrement Ocupacao by 1, saturating at 0.
REQ-012 In a given cycle, grants SHALL be limited to CAPACITY - Ocupacao (the registered value); competing lanes SHALL be served lowest index first; a same-cycle exit SHALL NOT free a space for that cycle.
REQ-013 Simultaneous grants and exit SHALL apply as a net update: Ocupacao_next = Ocupacao + grants - exit.
REQ-014 An ungranted MatrVal[i] rising edge in CLOSED SHALL pulse Recusado[i] for exactly one cycle and leave the lane CLOSED.
REQ-015 Cheio SHALL be combinational from registered Ocupacao.
REQ-016 Lanes SHALL be fully independent except for shared capacity arbitration.

Reset
REQ-017 On RSTn=0, asynchronously, all lanes SHALL go to CLOSED with counters at 0, Barreira=0, Recusado=0, Ocupacao=0, and the edge-detect registers cleared.
REQ-018 Reset mid-operation SHALL close every barrier immediately, with no occupancy retained.
REQ-019 An input held at 1 while RSTn deasserts SHALL NOT count as a rising edge until it returns to 0 and rises again.

Configuration
REQ-020 With macro BARR_HOLD_EN defined, the HOLD state and VehPresent SHALL behave as in REQ-008/REQ-009.
REQ-021 Without BARR_HOLD_EN, VehPresent SHALL be ignored, HOLD SHALL not exist, and OPEN SHALL always return to CLOSED when the counter reaches 0.

Verification
REQ-022 Defaults, one MatrVal[0] rise, VehPresent=0 -> Barreira[0]=1 for exactly 6 cycles, Ocupacao 0 -> 1.
REQ-023 BARR_HOLD_EN, VehPresent[0]=1 until cycle 10 after opening -> Barreira[0] high through cycle 10, low one cycle after VehPresent falls.
REQ-024 CAPACITY=1, MatrVal[0] and MatrVal[1] rise in the same cycle -> lane 0 opens, Recusado[1] pulses 1 cycle, Ocupacao=1, Cheio=1.
REQ-025 Ocupacao=CAPACITY, SaidaVal and MatrVal[0] rise in the same cycle -> entry refused, Ocupacao=CAPACITY-1; a later MatrVal[0] rise is granted.
REQ-026 Ocupacao=0, SaidaVal rise -> Ocupacao stays 0.
REQ-027 RSTn pulsed low at cycle 3 of an open lane -> Barreira=0 immediately, Ocupacao=0; MatrVal held high across reset produces no opening.
